tick_monitor: RTL and testbench
===============================

# tick_monitor

Checks a periodic single-cycle tick stream, such as the output of the design's interval timer, against its expected period. It measures each interval in clock cycles and flags early or late ticks. It raises a sticky alarm after a run of consecutive failures. It sits on the consuming side of the tick interface, as a functional monitor feeding the status/alarm logic.

## Interface
- `TIME_us`, 200: expected tick period in µs.
- `F_CLOCK_MHz`, 125: clock frequency in MHz; expected period N = `TIME_us*F_CLOCK_MHz` cycles (25000 at defaults).
- `TOL_CYCLES`, 4: allowed deviation; accepted window is [N−TOL, N+TOL].
- `MISS_LIMIT`, 3: consecutive failures that raise `alarm` (≥1).
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  monitor enable; low forces IDLE.
- `tick_in`  in  1  single-cycle tick pulse, synchronous to `clock`.
- `clear_err`  in  1  pulse; clears `alarm`, `err_count`, failure run.
- `period_ok`  out  1  one-cycle pulse: interval inside window.
- `early_err`  out  1  one-cycle pulse: interval < N−TOL.
- `late_err`  out  1  one-cycle pulse: no tick by N+TOL.
- `alarm`  out  1  sticky.
- `last_period`  out  CNT_W  last measured interval (stats build).
- `err_count`  out  8  saturating error count (stats build).
- CNT_W = `$clog2(N+TOL_CYCLES+2)`, a local parameter.

## Operation
- States: IDLE, ARM, MEASURE.
- IDLE: `cnt`=0 and no pulses. The block leaves IDLE for ARM on the first cycle `enable`=1.
- `enable`=0 in any state forces IDLE next cycle. `alarm`, `err_count` and `last_period` are held, not cleared.
- ARM: waits for the first `tick_in`. On a tick, `cnt`<=1 and the state moves to MEASURE. No result pulse is produced.
- MEASURE: `cnt` increments by 1 per cycle. At a tick, the measured interval P = `cnt` (ticks N cycles apart give P=N).
  - Tick with P < N−TOL: `early_err`. `cnt`<=1, stay in MEASURE.
  - Tick with N−TOL ≤ P ≤ N+TOL: `period_ok`. `cnt`<=1, stay in MEASURE.
  - No tick while `cnt`==N+TOL: `late_err`, go to ARM to resynchronise on the next tick.
- Every result event loads `last_period` with P (N+TOL+1 for late).
- Failure run counter:
  - Incremented by early/late, saturating at MISS_LIMIT.
  - Zeroed by `period_ok`.
  - `alarm`<=1 when the run reaches MISS_LIMIT.
- `err_count` increments on every early/late event and saturates at 255.
- `clear_err` zeroes `alarm`, the run counter and `err_count`. If an error event occurs in the same cycle, that event is counted after the clear: `err_count`=1, run=1, and `alarm` is set only if MISS_LIMIT=1.
- `cnt` never wraps; MEASURE leaves at N+TOL.

## Timing
- Reset: state IDLE, `cnt`=0, and all outputs 0.
- All outputs are registered. A result pulse asserts in the cycle after the `tick_in` sample, or after the cycle where `cnt`==N+TOL, for exactly 1 cycle.
- `alarm` rises in the same cycle as the error pulse that completes the run.
- `reset_n` asserted mid-interval clears everything immediately. After release the block restarts in IDLE; no pulse comes from the aborted interval.
- A tick coinciding with `enable` falling is ignored.
- A tick in the same cycle as a late timeout cannot occur: the tick takes precedence and is classified as in-window.

## Configuration
- `TICK_MON_STATS_EN` defined: `last_period` and the `err_count` register are implemented as described.
- `TICK_MON_STATS_EN` not defined:
  - Both `last_period` and `err_count` are tied to 0 and their registers are removed.
  - `alarm` and the failure run counter are unaffected.

## Test plan
All scenarios use default parameters: N=25000, TOL=4, MISS_LIMIT=3.
- Ticks every 25000 cycles after enable: first tick gives no pulse, then a `period_ok` pulse per tick; `last_period`=25000, `alarm`=0.
- Intervals 24996, 25004, 24995, 25005: ok, ok, `early_err`, then `late_err` one cycle after `cnt` reaches 25004; `err_count`=2.
- Three consecutive 20000-cycle intervals: `early_err` ×3, `alarm`=1 with the third; a following 25000 interval gives `period_ok` while `alarm` stays 1 until `clear_err`.
- `clear_err` in the same cycle as an `early_err` event: `err_count`=1, `alarm`=0.
- `reset_n` low for 3 cycles at `cnt`≈12000: all outputs 0, state IDLE; after release, the next tick only arms.
- Stats build off: the same stimulus as scenario 2 yields identical pulses, with `last_period`=0 and `err_count`=0.

Source files
------------

// File: rtl/tick_monitor.sv
// tick_monitor: measures tick intervals, flags early/late ticks, raises a sticky alarm after MISS_LIMIT consecutive failures.
// Define TICK_MON_STATS_EN to implement the last_period and err_count statistics registers.
module tick_monitor #(
    parameter int TIME_us = 200,
    parameter int F_CLOCK_MHz = 125,
    parameter int TOL_CYCLES = 4,
    parameter int MISS_LIMIT = 3,
    localparam int N = TIME_us * F_CLOCK_MHz,
    localparam int CNT_W = $clog2(N + TOL_CYCLES + 2)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             tick_in,
    input  logic             clear_err,
    output logic             period_ok,
    output logic             early_err,
    output logic             late_err,
    output logic             alarm,
    output logic [CNT_W-1:0] last_period,
    output logic [7:0]       err_count
);
    localparam int RUN_W = $clog2(MISS_LIMIT + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LO = CNT_W'(N - TOL_CYCLES);
    localparam logic [CNT_W-1:0] HI = CNT_W'(N + TOL_CYCLES);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MISS_LIMIT);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [RUN_W-1:0] run, run_base, run_nx;
    logic ok_ev, early_ev, late_ev, err_ev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A tick always restarts the count at 1, whether it arms or closes an interval.
    always_comb begin
        state_nx = !enable ? IDLE :
                   state == IDLE ? ARM :
                   state == ARM ? (tick_in ? MEASURE : ARM) :
                   (late_ev ? ARM : MEASURE);
        cnt_nx = state_nx == MEASURE ? (tick_in ? ONE : cnt + ONE) : '0;
    end

    always_comb begin
        ok_ev    = enable && state == MEASURE && tick_in && cnt >= LO;
        early_ev = enable && state == MEASURE && tick_in && cnt < LO;
        late_ev  = enable && state == MEASURE && !tick_in && cnt == HI;
        err_ev   = early_ev || late_ev;
        run_base = clear_err ? '0 : run;
        run_nx   = ok_ev ? '0 :
                   (err_ev && run_base != RUN_MAX) ? run_base + RUN_W'(1) : run_base;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_ok <= 1'b0;
            early_err <= 1'b0;
            late_err  <= 1'b0;
            alarm     <= 1'b0;
            run       <= '0;
        end else begin
            period_ok <= ok_ev;
            early_err <= early_ev;
            late_err  <= late_ev;
            run       <= run_nx;
            alarm     <= (alarm && !clear_err) || (err_ev && run_nx == RUN_MAX);
        end
    end

`ifdef TICK_MON_STATS_EN
    logic [7:0] err_base;

    assign err_base = clear_err ? 8'd0 : err_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_period <= '0;
            err_count   <= '0;
        end else begin
            if (ok_ev || err_ev)
                last_period <= late_ev ? HI + ONE : cnt;
            err_count <= (err_ev && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
        end
    end
`else
    assign last_period = '0;
    assign err_count   = '0;
`endif
endmodule

// File: tb/tb_tick_monitor.sv
// tb_tick_monitor: random and directed tick streams checked against a time-stamp based reference model.
module tb_tick_monitor;
    localparam int TUS = 1;
    localparam int FMHZ = 40;
    localparam int TOL = 4;
    localparam int ML = 3;
    localparam int N = TUS * FMHZ;
    localparam int CW = $clog2(N + TOL + 2);

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic tick_in = 1'b0;
    logic clear_err = 1'b0;
    logic period_ok, early_err, late_err, alarm;
    logic [CW-1:0] last_period;
    logic [7:0] err_count;

    tick_monitor #(
        .TIME_us(TUS),
        .F_CLOCK_MHz(FMHZ),
        .TOL_CYCLES(TOL),
        .MISS_LIMIT(ML)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .tick_in(tick_in),
        .clear_err(clear_err),
        .period_ok(period_ok),
        .early_err(early_err),
        .late_err(late_err),
        .alarm(alarm),
        .last_period(last_period),
        .err_count(err_count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    string phase = "reset";

    // Reference model: 0 idle, 1 waiting for first tick, 2 measuring since t_last.
    int mode = 0, now = 0, t_last = 0, run = 0, errs = 0, lastp = 0;
    bit e_ok = 0, e_ea = 0, e_la = 0, e_al = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [63:0] observed();
        return 64'({period_ok, early_err, late_err, alarm, last_period, err_count});
    endfunction

    function automatic logic [63:0] expected();
`ifdef TICK_MON_STATS_EN
        return 64'({e_ok, e_ea, e_la, e_al, CW'(lastp), 8'(errs)});
`else
        return 64'({e_ok, e_ea, e_la, e_al, CW'(0), 8'd0});
`endif
    endfunction

    task automatic cyc(input bit en, input bit tk, input bit clr);
        int p;
        enable = en;
        tick_in = tk;
        clear_err = clr;
        e_ok = 0;
        e_ea = 0;
        e_la = 0;
        p = now - t_last;
        if (!en) mode = 0;
        else if (mode == 0) mode = 1;
        else if (mode == 1) begin
            if (tk) begin
                mode = 2;
                t_last = now;
            end
        end else if (tk) begin
            if (p < N - TOL) e_ea = 1;
            else e_ok = 1;
            t_last = now;
        end else if (p == N + TOL) begin
            e_la = 1;
            mode = 1;
        end
        if (clr) begin
            run = 0;
            errs = 0;
            e_al = 0;
        end
        if (e_ea || e_la) begin
            run = run < ML ? run + 1 : ML;
            errs = errs < 255 ? errs + 1 : 255;
            lastp = e_la ? N + TOL + 1 : p;
            if (run == ML) e_al = 1;
        end
        if (e_ok) begin
            run = 0;
            lastp = p;
        end
        @(posedge clock);
        #1;
        now++;
        check(phase, observed(), expected());
    endtask

    task automatic interval(input int n, input bit clr);
        repeat (n - 1) cyc(1, 0, 0);
        cyc(1, 1, clr);
    endtask

    task automatic do_reset(input int n);
        reset_n = 0;
        tick_in = 0;
        clear_err = 0;
        mode = 0;
        run = 0;
        errs = 0;
        lastp = 0;
        {e_ok, e_ea, e_la, e_al} = '0;
        #1;
        check("reset_now", observed(), 64'd0);
        repeat (n) @(posedge clock);
        #1;
        check("reset_hold", observed(), 64'd0);
        reset_n = 1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        enable = 1;
        do_reset(3);

        phase = "nominal";
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (4) interval(N, 0);

        phase = "window_edges";
        interval(N - TOL, 0);
        interval(N + TOL, 0);
        interval(N - TOL - 1, 0);
        interval(N + TOL + 1, 0);
        interval(N, 0);

        phase = "alarm_run";
        repeat (3) interval(N / 2, 0);
        interval(N, 0);
        interval(N, 0);
        cyc(1, 0, 1);

        phase = "clear_with_err";
        interval(N - TOL - 5, 1);
        interval(N, 0);

        phase = "mid_reset";
        repeat (N / 2) cyc(1, 0, 0);
        do_reset(3);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        interval(N, 0);

        phase = "enable_drop";
        repeat (10) cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        interval(N, 0);

        phase = "err_saturate";
        repeat (260) cyc(1, 1, 0);
        cyc(1, 0, 1);
        interval(N, 0);

        phase = "random";
        repeat (300) begin
            int r, gap;
            r = int'($urandom_range(0, 9));
            gap = r < 2 ? int'($urandom_range(1, N - TOL - 1)) :
                  r < 8 ? int'($urandom_range(N - TOL, N + TOL)) :
                          int'($urandom_range(N + TOL + 1, N + TOL + 8));
            if ($urandom_range(0, 19) == 0) cyc(0, 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 9) == 0) cyc(1, 0, 1);
            interval(gap, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
